// File: rtl/i2c_pkg.sv
// Shared types and default timing for the I2C SCL generator.
// FSM state encoding plus default phase and timeout lengths.
package i2c_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOW       = 2'd1,
    WAIT_HIGH = 2'd2,
    HIGH      = 2'd3
  } scl_state_e;

  localparam int I2C_LOW_CNT  = 250;
  localparam int I2C_HIGH_CNT = 141;
  localparam int I2C_TIMEOUT  = 65535;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser with a parameterised reset value.
// Ports: CLK, RST_N (async low), d (async in), q (synced out).
module sync_2ff #(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/i2c_scl_gen.sv
// I2C SCL generator: programmable low/high phases, clock stretching
// with timeout, wired-AND synchronisation and phase ticks.
// Ports: CLK, RST_N, en (run request), scl_i (pin readback),
// scl_t (1 = release), busy, fall_tick, sample_tick, stretch,
// sync_lost, timeout. All outputs are registered.
module i2c_scl_gen
  import i2c_pkg::*;
#(
  parameter int          LOW_CNT     = I2C_LOW_CNT,
  parameter int          HIGH_CNT    = I2C_HIGH_CNT,
  parameter int          CNT_W       = 9,
  parameter int unsigned TIMEOUT_CNT = I2C_TIMEOUT,
  parameter int          TO_W        = 16
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic en,
  input  logic scl_i,
  output logic scl_t,
  output logic busy,
  output logic fall_tick,
  output logic sample_tick,
  output logic stretch,
  output logic sync_lost,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(LOW_CNT - 1);
  localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(HIGH_CNT - 1);
  localparam logic [CNT_W-1:0] SAMPLE_AT = CNT_W'(HIGH_CNT / 2);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(TIMEOUT_CNT - 1);

  if (LOW_CNT < 4) begin : g_low_chk
    $error("LOW_CNT must be at least 4");
  end
  if (HIGH_CNT < 4) begin : g_high_chk
    $error("HIGH_CNT must be at least 4");
  end
  if (CNT_W < $clog2(max2(LOW_CNT, HIGH_CNT))) begin : g_cnt_chk
    $error("CNT_W too narrow for phase lengths");
  end
  if (TIMEOUT_CNT < 2) begin : g_to_chk
    $error("TIMEOUT_CNT must be at least 2");
  end
  if (TO_W < $clog2(TIMEOUT_CNT)) begin : g_tow_chk
    $error("TO_W too narrow for TIMEOUT_CNT");
  end

  logic scl_s;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_sync (
    .CLK   (CLK),
    .RST_N (RST_N),
    .d     (scl_i),
    .q     (scl_s)
  );

  scl_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [TO_W-1:0]  to_cnt, to_n;
  logic             sync_lost_n;
  logic             timeout_n;

  // The WAIT_HIGH cycle that first sees scl_s high is count 0
  // of the high phase, so HIGH is entered at count 1.
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    to_n        = to_cnt;
    sync_lost_n = 1'b0;
    timeout_n   = 1'b0;
    unique case (state)
      IDLE: begin
        cnt_n = '0;
        to_n  = '0;
        if (en) begin
          state_n = LOW;
        end
      end
      LOW: begin
        if (cnt == LOW_LAST) begin
          state_n = WAIT_HIGH;
          cnt_n   = '0;
          to_n    = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_HIGH: begin
        if (scl_s) begin
          state_n = HIGH;
          cnt_n   = CNT_ONE;
          to_n    = '0;
        end else if (to_cnt == TO_LAST) begin
          state_n   = IDLE;
          timeout_n = 1'b1;
          to_n      = '0;
        end else begin
          to_n = to_cnt + 1'b1;
        end
      end
      HIGH: begin
        // External pull-low beats end-of-phase handling.
        if (!scl_s) begin
          state_n     = LOW;
          cnt_n       = '0;
          sync_lost_n = 1'b1;
        end else if (cnt == HIGH_LAST) begin
          state_n = en ? LOW : IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        to_n    = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= IDLE;
      cnt    <= '0;
      to_cnt <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      to_cnt <= to_n;
    end
  end

  // Outputs are decoded from the next state so each one lines up
  // with the state it describes while still coming from a flop.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      scl_t       <= 1'b1;
      busy        <= 1'b0;
      fall_tick   <= 1'b0;
      sample_tick <= 1'b0;
      stretch     <= 1'b0;
      sync_lost   <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      scl_t       <= (state_n != LOW);
      busy        <= (state_n != IDLE);
      fall_tick   <= (state_n == LOW) && (state != LOW);
      sample_tick <= (state_n == HIGH) && (cnt_n == SAMPLE_AT);
      stretch     <= (state_n == WAIT_HIGH);
      sync_lost   <= sync_lost_n;
      timeout     <= timeout_n;
    end
  end

endmodule
